// File: rtl/ifft_b2s_cp_sequencer.sv
// ifft_b2s_cp_sequencer: read-side controller for the IFFT block-to-stream
// buffer. Walks the ping-pong banks in round-robin order, prepends the cyclic
// prefix by starting each symbol at address N-cp, aligns stream markers to the
// buffer read latency and hands each bank back to the writer once read out.
// Optional build macro: IFFT_B2S_UFLOW_CNT_EN adds a saturating underflow
// event counter (uflow_cnt) with a synchronous clear input (uflow_clr).
module ifft_b2s_cp_sequencer #(
    parameter int MAX_LOG2N = 12,
    parameter int NUM_BANKS = 2,
    parameter int RD_LAT    = 2,
    localparam int BW       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic                 sample_en,
    input  logic [3:0]           cfg_log2n,
    input  logic [MAX_LOG2N-1:0] cfg_cp_len,
    input  logic [NUM_BANKS-1:0] bank_full,
    output logic [NUM_BANKS-1:0] bank_release,
    output logic                 rd_en,
    output logic [BW-1:0]        rd_bank,
    output logic [MAX_LOG2N-1:0] rd_addr,
    output logic                 out_valid,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 underflow,
    output logic                 cfg_err,
    output logic                 busy
`ifdef IFFT_B2S_UFLOW_CNT_EN
    ,
    input  logic                 uflow_clr,
    output logic [15:0]          uflow_cnt
`endif
);

    localparam int AW = MAX_LOG2N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CP,
        S_BODY,
        S_REL
    } state_t;

    state_t          state, state_d;
    logic [BW-1:0]   ptr, ptr_d, ptr_nxt;
    logic [AW-1:0]   cnt, cnt_d;
    logic [3:0]      lg_q, lg_d;
    logic            first_q, first_d;
    logic            uflow_set, cfgerr_set, latch;
    logic            sop_tag, eop_tag;
    logic [AW-1:0]   n_last;

    // Candidate symbol configuration, evaluated from the live cfg inputs and
    // only committed when a symbol actually starts.
    logic            lg_ok, cp_ok;
    logic [3:0]      lg_new;
    logic [AW:0]     n_new;
    logic [AW-1:0]   cp_new, start_new;

    logic [RD_LAT-1:0] v_sr, s_sr, e_sr;

    assign n_last  = AW'(((AW+1)'(1) << lg_q) - (AW+1)'(1));
    assign ptr_nxt = (ptr == BW'(NUM_BANKS - 1)) ? '0 : ptr + BW'(1);
    assign rd_bank = ptr;
    assign rd_addr = cnt;
    assign busy    = (state != S_IDLE);

    // Legalise the requested size and CP length; an illegal size falls back to
    // the largest IFFT, an over-long CP is dropped entirely.
    always_comb begin
        lg_ok     = (cfg_log2n >= 4'd7) && (cfg_log2n <= 4'(MAX_LOG2N));
        lg_new    = lg_ok ? cfg_log2n : 4'(MAX_LOG2N);
        n_new     = (AW+1)'(1) << lg_new;
        cp_ok     = ({1'b0, cfg_cp_len} < n_new);
        cp_new    = cp_ok ? cfg_cp_len : '0;
        start_new = (cp_new == '0) ? '0 : AW'(n_new - {1'b0, cp_new});
    end

    // Next-state logic, read strobes, marker tags and bank hand-back.
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        cnt_d        = cnt;
        lg_d         = lg_q;
        first_d      = first_q;
        uflow_set    = 1'b0;
        cfgerr_set   = 1'b0;
        latch        = 1'b0;
        rd_en        = 1'b0;
        sop_tag      = 1'b0;
        eop_tag      = 1'b0;
        bank_release = '0;
        case (state)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!enable)             state_d = S_IDLE;
                else if (bank_full[ptr]) latch   = 1'b1;
            end
            S_CP: begin
                if (sample_en) begin
                    rd_en   = 1'b1;
                    sop_tag = first_q;
                    first_d = 1'b0;
                    if (cnt == n_last) begin
                        cnt_d   = '0;
                        state_d = S_BODY;
                    end else begin
                        cnt_d = cnt + AW'(1);
                    end
                end
            end
            S_BODY: begin
                if (sample_en) begin
                    rd_en   = 1'b1;
                    sop_tag = first_q;
                    first_d = 1'b0;
                    if (cnt == n_last) begin
                        eop_tag = 1'b1;
                        state_d = S_REL;
                    end else begin
                        cnt_d = cnt + AW'(1);
                    end
                end
            end
            S_REL: begin
                bank_release[ptr] = 1'b1;
                ptr_d             = ptr_nxt;
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (bank_full[ptr_nxt]) begin
                    latch = 1'b1;
                end else begin
                    uflow_set = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (latch) begin
            lg_d       = lg_new;
            cnt_d      = start_new;
            first_d    = 1'b1;
            cfgerr_set = !lg_ok || !cp_ok;
            state_d    = (cp_new == '0) ? S_BODY : S_CP;
        end
    end

    // FSM, bank pointer, address counter, latched size and sticky flags.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            lg_q      <= 4'(MAX_LOG2N);
            first_q   <= 1'b0;
            underflow <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
            lg_q    <= lg_d;
            first_q <= first_d;
            if (uflow_set)  underflow <= 1'b1;
            if (cfgerr_set) cfg_err   <= 1'b1;
        end
    end

    // Delay read strobe and marker tags by the buffer read latency.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            v_sr <= '0;
            s_sr <= '0;
            e_sr <= '0;
        end else begin
            v_sr[0] <= rd_en;
            s_sr[0] <= sop_tag;
            e_sr[0] <= eop_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                s_sr[i] <= s_sr[i-1];
                e_sr[i] <= e_sr[i-1];
            end
        end
    end

    assign out_valid = v_sr[RD_LAT-1];
    assign out_sop   = s_sr[RD_LAT-1];
    assign out_eop   = e_sr[RD_LAT-1];

`ifdef IFFT_B2S_UFLOW_CNT_EN
    // Saturating count of underflow events; clear takes priority.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            uflow_cnt <= '0;
        end else if (uflow_clr) begin
            uflow_cnt <= '0;
        end else if (uflow_set && (uflow_cnt != 16'hFFFF)) begin
            uflow_cnt <= uflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifft_b2s_cp_sequencer.sv
// Testbench for ifft_b2s_cp_sequencer: scoreboard of expected reads and
// delayed stream markers, plus directed checks on release, flags and reset.
module tb_ifft_b2s_cp_sequencer;

    localparam int MAX_LOG2N = 12;
    localparam int NUM_BANKS = 2;
    localparam int RD_LAT    = 2;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic        sample_en;
    logic [3:0]  cfg_log2n;
    logic [11:0] cfg_cp_len;
    logic [1:0]  bank_full;
    logic [1:0]  bank_release;
    logic        rd_en;
    logic [0:0]  rd_bank;
    logic [11:0] rd_addr;
    logic        out_valid, out_sop, out_eop;
    logic        underflow, cfg_err, busy;
`ifdef IFFT_B2S_UFLOW_CNT_EN
    logic        uflow_clr;
    logic [15:0] uflow_cnt;
`endif

    ifft_b2s_cp_sequencer #(
        .MAX_LOG2N(MAX_LOG2N),
        .NUM_BANKS(NUM_BANKS),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .areset(areset),
        .enable(enable),
        .sample_en(sample_en),
        .cfg_log2n(cfg_log2n),
        .cfg_cp_len(cfg_cp_len),
        .bank_full(bank_full),
        .bank_release(bank_release),
        .rd_en(rd_en),
        .rd_bank(rd_bank),
        .rd_addr(rd_addr),
        .out_valid(out_valid),
        .out_sop(out_sop),
        .out_eop(out_eop),
        .underflow(underflow),
        .cfg_err(cfg_err),
        .busy(busy)
`ifdef IFFT_B2S_UFLOW_CNT_EN
        ,
        .uflow_clr(uflow_clr),
        .uflow_cnt(uflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]  bank;
        logic [11:0] addr;
        bit          sop;
        bit          eop;
    } rd_t;

    typedef struct {
        int cyc;
        bit sop;
        bit eop;
    } out_t;

    rd_t        rd_q[$];
    out_t       out_q[$];
    logic [1:0] rel_q[$];
    int         sop_cyc_q[$];
    int         eop_cyc_q[$];

    int cyc         = 0;
    int rd_cnt      = 0;
    int last_rd_cyc = 0;
    int check_count = 0;
    int pass_count  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_count++;
        if (got === want) pass_count++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected read sequence of one symbol: CP tail of the block, then the body.
    task automatic pushSymbol(input logic [0:0] bank, input int lg, input int cp);
        int  n;
        rd_t e;
        n = 1 << lg;
        for (int i = 0; i < cp; i++) begin
            e.bank = bank; e.addr = 12'(n - cp + i); e.sop = (i == 0); e.eop = 1'b0;
            rd_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.bank = bank; e.addr = 12'(i); e.sop = (cp == 0) && (i == 0); e.eop = (i == n - 1);
            rd_q.push_back(e);
        end
    endtask

    task automatic clearBoard();
        rd_q.delete();
        out_q.delete();
        rel_q.delete();
        sop_cyc_q.delete();
        eop_cyc_q.delete();
        rd_cnt = 0;
    endtask

    task automatic doReset();
        areset     = 1'b1;
        enable     = 1'b0;
        sample_en  = 1'b1;
        bank_full  = 2'b00;
        cfg_log2n  = 4'd7;
        cfg_cp_len = 12'd0;
`ifdef IFFT_B2S_UFLOW_CNT_EN
        uflow_clr  = 1'b0;
`endif
        #1;
        clearBoard();
        tick(2);
        areset = 1'b0;
        tick(1);
    endtask

    // Configure and start a symbol; enable is held for two cycles (enough to
    // leave IDLE and latch), then optionally dropped so the run ends at REL.
    task automatic applyStimulus(input logic [3:0] lg, input logic [11:0] cp,
                                 input logic [1:0] full, input bit hold_enable);
        cfg_log2n  = lg;
        cfg_cp_len = cp;
        bank_full  = full;
        enable     = 1'b1;
        tick(2);
        if (!hold_enable) enable = 1'b0;
    endtask

    task automatic waitDrain(input int budget, input bit toggle);
        int n;
        n = 0;
        while ((rd_q.size() != 0 || out_q.size() != 0) && n < budget) begin
            tick(1);
            if (toggle) sample_en = ~sample_en;
            n++;
        end
        if (rd_q.size() != 0 || out_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(rd_q.size() + out_q.size()), 64'd0);
            rd_q.delete();
            out_q.delete();
        end
        sample_en = 1'b1;
        tick(3);
    endtask

    // Monitor: compare reads and delayed stream outputs against the scoreboard.
    always @(negedge clk) begin
        rd_t  e;
        out_t o;
        cyc++;
        if (!areset) begin
            if (rd_en) begin
                rd_cnt++;
                if (rd_q.size() == 0) begin
                    checkOutput("rd_unexpected", {rd_bank, rd_addr}, 64'hFFFF_FFFF);
                end else begin
                    e = rd_q.pop_front();
                    checkOutput("rd_bank_addr", {rd_bank, rd_addr}, {e.bank, e.addr});
                    o.cyc = cyc + RD_LAT; o.sop = e.sop; o.eop = e.eop;
                    out_q.push_back(o);
                    if (e.sop) sop_cyc_q.push_back(cyc);
                    if (e.eop) eop_cyc_q.push_back(cyc);
                end
                last_rd_cyc = cyc;
            end
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    checkOutput("out_unexpected", {out_sop, out_eop}, 64'hFF);
                end else begin
                    o = out_q.pop_front();
                    checkOutput("out_cycle_sop_eop", {32'(cyc), out_sop, out_eop},
                                {32'(o.cyc), o.sop, o.eop});
                end
            end else if (out_sop || out_eop) begin
                checkOutput("marker_without_valid", {out_sop, out_eop}, 64'd0);
            end
            if (bank_release != 2'b00) begin
                rel_q.push_back(bank_release);
                checkOutput("release_after_last_read", 64'(cyc - last_rd_cyc), 64'd1);
            end
        end
    end

    initial begin
        int set_cyc;
        int n;

        // Reset state
        areset = 1'b1; enable = 1'b0; sample_en = 1'b0; bank_full = 2'b00;
        cfg_log2n = 4'd7; cfg_cp_len = 12'd0;
`ifdef IFFT_B2S_UFLOW_CNT_EN
        uflow_clr = 1'b0;
`endif
        #2;
        checkOutput("reset_outputs",
                    {rd_en, rd_bank, rd_addr, bank_release, out_valid, out_sop, out_eop,
                     underflow, cfg_err, busy}, 64'd0);
`ifdef IFFT_B2S_UFLOW_CNT_EN
        checkOutput("reset_uflow_cnt", 64'(uflow_cnt), 64'd0);
`endif

        // Basic symbol: N=128, cp=9 on bank 0
        doReset();
        pushSymbol(1'b0, 7, 9);
        applyStimulus(4'd7, 12'd9, 2'b01, 1'b0);
        waitDrain(400, 1'b0);
        checkOutput("basic_release_count", 64'(rel_q.size()), 64'd1);
        if (rel_q.size() > 0) checkOutput("basic_release_bank", rel_q[0], 2'b01);
        checkOutput("basic_reads", 64'(rd_cnt), 64'd137);
        checkOutput("basic_flags_idle", {underflow, cfg_err, busy}, 64'd0);

        // Back-to-back symbols on both banks
        doReset();
        pushSymbol(1'b0, 7, 9);
        pushSymbol(1'b1, 7, 9);
        applyStimulus(4'd7, 12'd9, 2'b11, 1'b1);
        n = 0;
        while (rel_q.size() == 0 && n < 400) begin
            tick(1);
            n++;
        end
        enable = 1'b0;
        waitDrain(600, 1'b0);
        checkOutput("b2b_release_count", 64'(rel_q.size()), 64'd2);
        if (rel_q.size() == 2) checkOutput("b2b_release_seq", {rel_q[0], rel_q[1]}, 4'b0110);
        if (sop_cyc_q.size() == 2 && eop_cyc_q.size() == 2)
            checkOutput("b2b_gap", 64'(sop_cyc_q[1] - eop_cyc_q[0]), 64'd2);
        else
            checkOutput("b2b_marker_count", 64'(sop_cyc_q.size() + eop_cyc_q.size()), 64'd4);
        checkOutput("b2b_underflow", 64'(underflow), 64'd0);

        // Underflow: only bank 0 full, enable held
        doReset();
        pushSymbol(1'b0, 7, 9);
        applyStimulus(4'd7, 12'd9, 2'b01, 1'b1);
        waitDrain(400, 1'b0);
        checkOutput("uflow_flag_wait", {underflow, busy, rd_en}, 3'b110);
`ifdef IFFT_B2S_UFLOW_CNT_EN
        checkOutput("uflow_cnt_one", 64'(uflow_cnt), 64'd1);
`endif
        tick(17);
        set_cyc = cyc;
        pushSymbol(1'b1, 7, 9);
        bank_full = 2'b11;
        tick(2);
        enable = 1'b0;
        waitDrain(400, 1'b0);
        if (sop_cyc_q.size() == 2) checkOutput("uflow_restart_cycle", 64'(sop_cyc_q[1]), 64'(set_cyc + 2));
        else checkOutput("uflow_sop_count", 64'(sop_cyc_q.size()), 64'd2);
        if (rel_q.size() == 2) checkOutput("uflow_release_seq", {rel_q[0], rel_q[1]}, 4'b0110);
        else checkOutput("uflow_release_count", 64'(rel_q.size()), 64'd2);
`ifdef IFFT_B2S_UFLOW_CNT_EN
        uflow_clr = 1'b1;
        tick(1);
        uflow_clr = 1'b0;
        checkOutput("uflow_cnt_clear", 64'(uflow_cnt), 64'd0);
`endif

        // cp = 0: symbol starts at address 0
        doReset();
        pushSymbol(1'b0, 7, 0);
        applyStimulus(4'd7, 12'd0, 2'b01, 1'b0);
        waitDrain(400, 1'b0);
        checkOutput("cp0_cfg_err", 64'(cfg_err), 64'd0);

        // cp = N: illegal, CP dropped
        doReset();
        pushSymbol(1'b0, 7, 0);
        applyStimulus(4'd7, 12'd128, 2'b01, 1'b0);
        waitDrain(400, 1'b0);
        checkOutput("cpN_cfg_err_reads", {cfg_err, 16'(rd_cnt)}, {1'b1, 16'd128});

        // log2n = 3: illegal, falls back to N = 4096 with cp = 9
        doReset();
        pushSymbol(1'b0, 12, 9);
        applyStimulus(4'd3, 12'd9, 2'b01, 1'b0);
        waitDrain(5000, 1'b0);
        checkOutput("lg3_cfg_err_reads", {cfg_err, 16'(rd_cnt)}, {1'b1, 16'd4105});

        // Strobed rate: sample_en alternating
        doReset();
        pushSymbol(1'b0, 7, 9);
        applyStimulus(4'd7, 12'd9, 2'b01, 1'b0);
        waitDrain(800, 1'b1);
        if (sop_cyc_q.size() == 1 && eop_cyc_q.size() == 1)
            checkOutput("strobe_span", 64'(eop_cyc_q[0] - sop_cyc_q[0]), 64'd272);
        else
            checkOutput("strobe_marker_count", 64'(sop_cyc_q.size() + eop_cyc_q.size()), 64'd2);

        // Reset mid-BODY after 50 reads
        doReset();
        pushSymbol(1'b0, 7, 9);
        applyStimulus(4'd7, 12'd9, 2'b11, 1'b0);
        n = 0;
        while (rd_cnt < 50 && n < 200) begin
            tick(1);
            n++;
        end
        checkOutput("mid_reads_before_reset", 64'(rd_cnt), 64'd50);
        areset = 1'b1;
        #1;
        checkOutput("mid_reset_outputs",
                    {rd_en, rd_bank, rd_addr, bank_release, out_valid, out_sop, out_eop, busy}, 64'd0);
        checkOutput("mid_no_release", 64'(rel_q.size()), 64'd0);
        clearBoard();
        tick(2);
        areset = 1'b0;
        tick(1);
        pushSymbol(1'b0, 7, 9);
        applyStimulus(4'd7, 12'd9, 2'b11, 1'b0);
        waitDrain(400, 1'b0);
        if (rel_q.size() == 1) checkOutput("mid_rerun_release", rel_q[0], 2'b01);
        else checkOutput("mid_rerun_release_count", 64'(rel_q.size()), 64'd1);

        checkOutput("scoreboard_empty", 64'(rd_q.size() + out_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ifft_b2s_cp_sequencer.md
Name: ifft_b2s_cp_sequencer

Overview:
- Read-side controller for the IFFT block-to-stream buffer in the low-PHY DL chain.
- The IFFT writer fills NUM_BANKS ping-pong banks, one complete IFFT block per bank.
- This block reads the banks strictly in round-robin order and generates bank/address/enable reads that prepend the cyclic prefix (CP) to each symbol.
- It drives stream-side valid/sop/eop aligned to the buffer read latency and hands each bank back to the writer when that bank is done.

Parameters:
MAX_LOG2N, 12, log2 of the largest supported IFFT size (4096)
NUM_BANKS, 2, number of ping-pong banks (2..4)
RD_LAT, 2, buffer read latency in clk cycles (1..4)

Ports:
clk  in  1  clock
areset  in  1  asynchronous active-high reset
enable  in  1  run; sampled at symbol boundaries only
sample_en  in  1  output-rate strobe; one read issued per strobe
cfg_log2n  in  4  IFFT size log2, legal 7..MAX_LOG2N; latched at symbol start
cfg_cp_len  in  MAX_LOG2N  CP length in samples; latched at symbol start
bank_full  in  NUM_BANKS  level per bank: writer has completed the block
bank_release  out  NUM_BANKS  1-cycle pulse: bank free for writer
rd_en  out  1  buffer read strobe
rd_bank  out  clog2(NUM_BANKS)  bank being read
rd_addr  out  MAX_LOG2N  sample address within bank
out_valid  out  1  read data valid at buffer output (rd_en delayed RD_LAT)
out_sop  out  1  first CP sample of symbol, aligned to out_valid
out_eop  out  1  last body sample of symbol, aligned to out_valid
underflow  out  1  sticky: next bank not full at symbol boundary while enabled
cfg_err  out  1  sticky: illegal cfg_log2n or cfg_cp_len >= N
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM = IDLE; bank pointer = 0; delay lines cleared. Reset mid-symbol abandons the symbol with no release pulse.
- Internal constants: N = 1 << log2n_q; cp_q = latched CP length.
- FSM states: IDLE, WAIT, CP, BODY, REL.
- IDLE -> WAIT when enable = 1.
- WAIT, on each cycle:
  - enable = 0 -> IDLE.
  - else if bank_full[ptr] = 1 -> latch config, then go to CP (or BODY if effective cp = 0); address counter = N - cp_q, or 0 when cp = 0.
  - else stay in WAIT.
- Config checks at latch:
  - cfg_log2n outside 7..MAX_LOG2N: set cfg_err, use MAX_LOG2N.
  - cfg_cp_len >= N: set cfg_err, effective cp = 0.
- CP:
  - Each sample_en cycle: rd_en = 1, rd_addr = counter, counter++.
  - After the read at address N-1, go to BODY with counter = 0.
- BODY:
  - Each sample_en cycle: read at counter.
  - After the read at N-1, go to REL.
- REL (one cycle):
  - bank_release[ptr] = 1; ptr advances with wrap (NUM_BANKS-1 -> 0).
  - If enable = 1 and bank_full[new ptr] = 1: latch config and go straight to CP/BODY. No extra gap; the first read can issue on the next sample_en.
  - If enable = 1 and the bank is not full: set underflow, go to WAIT.
  - If enable = 0: go to IDLE.
- sample_en = 0 in CP/BODY: no read, counter holds. Only sample_en gates reads.
- Read qualification: rd_en = sample_en and state in {CP, BODY}.
- Markers:
  - sop tag = first read of symbol.
  - eop tag = BODY read at N-1.
  - rd_en, sop tag and eop tag each pass through an RD_LAT-stage shift register to form out_valid, out_sop, out_eop.
- The block never reads a bank whose bank_full = 0.
- bank_full falling during a read of that bank is ignored; the writer contract forbids it.
- Reads per symbol = cp + N. The following are reflected only at the next symbol latch, never mid-symbol: cfg changes, enable deasserting, underflow clearing.

Optional Feature:
- Macro: IFFT_B2S_UFLOW_CNT_EN.
- When defined:
  - Adds output uflow_cnt (16 bits): saturating count of underflow events, incremented on each REL->WAIT underflow transition.
  - Adds input uflow_clr (1 bit): synchronous clear; clear wins over a simultaneous increment.
  - Resets to 0.
- When undefined: neither port exists, and only the sticky underflow flag remains.

Test Plan:
- Basic symbol: log2n = 7, cp = 9, sample_en = 1, bank_full = 01.
  - rd_addr = 119..127 then 0..127 on bank 0: 137 reads.
  - out_sop with the addr-119 data, 2 cycles after that read.
  - out_eop with addr-127 BODY data.
  - bank_release = 01 pulse the cycle after the last read.
- Back-to-back: both banks full, 2 symbols.
  - Bank 0 then bank 1 with exactly one REL cycle between last and first read.
  - release 01 then 10.
  - underflow = 0.
- Underflow: bank_full = 01 only.
  - After bank 0: underflow = 1, FSM in WAIT.
  - Assert bank_full[1] 20 cycles later -> bank-1 reads start next cycle.
  - With IFFT_B2S_UFLOW_CNT_EN: uflow_cnt = 1.
- Boundary config:
  - cp = 0 -> first read addr 0, out_sop with addr 0.
  - cp = 128 with log2n = 7 -> cfg_err = 1, 128 reads, no CP.
  - log2n = 3 -> cfg_err = 1, N = 4096.
- Strobed rate: sample_en toggling 1,0,1,0 -> reads only on strobe cycles; 137 reads span 273 cycles; out_valid pattern identical, shifted by RD_LAT.
- Reset mid-BODY: areset after 50 reads -> all outputs 0 immediately, no release pulse, ptr = 0; next run restarts bank 0 at its CP start.
